// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the handshaked sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_LSL   = 4'b0011,
    OP_LSR   = 4'b0100,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_UDIV  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Divide by zero short-circuits to a zero result, so it never iterates.
  function automatic logic is_iterative(input logic [3:0] op, input logic divisor_zero);
    return (op == OP_MUL) || ((op == OP_UDIV) && !divisor_zero);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative WIDTH-cycle datapath: shift-add multiply or restoring unsigned divide.
module alu_iter_muldiv #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // acc_q: product accumulator (MUL) or partial remainder (UDIV).
  // opa_q: multiplicand shifting left (MUL) or dividend->quotient shifter (UDIV).
  // opb_q: multiplier shifting right (MUL) or fixed divisor (UDIV).
  logic             busy_q, is_div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    trial = '0;
    q_bit = 1'b0;
    if (is_div_q) begin
      trial = {acc_q, opa_q[WIDTH-1]};
      q_bit = (trial >= {1'b0, opb_q});
      acc_d = q_bit ? (trial[WIDTH-1:0] - opb_q) : trial[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], q_bit};
    end else begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end
  end

  // The final iteration's next value is the answer, so the top can latch it on the done cycle.
  assign result_o = is_div_q ? opa_d : acc_d;
  assign done_o   = busy_q && (cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= a_i;
      opb_q    <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready handshakes; single-cycle logic ops plus iterative MUL/UDIV.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] bus_w_q;
  logic             zero_q, neg_q, carry_q, ovf_q, out_valid_q;

  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf;
  logic             accept, start_iter, iter_done;
  logic [WIDTH-1:0] iter_res;
  logic [SW-1:0]    shamt;

  // in_ready is forced low while reset is held so every output reads 0 during reset.
  assign in_ready   = resetl && (state_q == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iterative(ALUCtrl, BusB == '0);
  assign shamt      = BusB[SW-1:0];

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ALUCtrl)
      OP_AND:   sc_res = BusA & BusB;
      OP_OR:    sc_res = BusA | BusB;
      OP_PASSB: sc_res = BusB;
      OP_LSL:   sc_res = BusA << shamt;
      OP_LSR:   sc_res = BusA >> shamt;
      OP_ADD: begin
        {sc_carry, sc_res} = {1'b0, BusA} + {1'b0, BusB};
        sc_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sc_res[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        // A + ~B + 1: carry-out is the inverted borrow.
        {sc_carry, sc_res} = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};
        sc_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sc_res[WIDTH-1] != BusA[WIDTH-1]);
      end
      default:  sc_res = '0;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk      (CLK),
    .rst_n    (resetl),
    .start_i  (start_iter),
    .is_div_i (ALUCtrl == OP_UDIV),
    .a_i      (BusA),
    .b_i      (BusB),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  // NOTE: reset clears every output register so an aborted operation can never surface a stale result.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q     <= ST_IDLE;
      bus_w_q     <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_iter) begin
            state_q <= ST_CALC;
          end else if (accept) begin
            bus_w_q     <= sc_res;
            zero_q      <= (sc_res == '0);
            neg_q       <= sc_res[WIDTH-1];
            carry_q     <= sc_carry;
            ovf_q       <= sc_ovf;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_CALC: begin
          if (iter_done) begin
            bus_w_q     <= iter_res;
            zero_q      <= (iter_res == '0);
            neg_q       <= iter_res[WIDTH-1];
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign BusW      = bus_w_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         resetl;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] BusA, BusB, BusW;
  logic [3:0]   ALUCtrl;
  logic         Zero, Negative, Carry, Overflow;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BusA      (BusA),
    .BusB      (BusB),
    .ALUCtrl   (ALUCtrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .BusW      (BusW),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic definitions (wide signed sums for overflow).
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic signed [W+1:0] sa, sb, s;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a + b;
        c = (r < a);
        s = sa + sb;
        v = (s != {{2{r[W-1]}}, r});
      end
      4'b0110: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s != {{2{r[W-1]}}, r});
      end
      4'b0111: r = b;
      4'b0011: r = a << (b % W);
      4'b0100: r = a >> (b % W);
      4'b1000: r = a * b;
      4'b1001: r = (b == '0) ? '0 : a / b;
      default: r = '0;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit junk);
    logic [W-1:0] er;
    logic         ec, ev;
    int           exp_lat, lat;
    model(op, a, b, er, ec, ev);
    exp_lat = (op == 4'b1000 || (op == 4'b1001 && b != '0)) ? W + 1 : 1;
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * W) begin
      check("in_ready_calc", W'(in_ready), W'(0));
      if (junk) begin
        in_valid = 1'b1;
        ALUCtrl  = 4'($urandom);
        BusA     = {$urandom, $urandom};
        BusB     = {$urandom, $urandom};
      end
      @(negedge CLK);
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("latency op=%b", op), W'(lat), W'(exp_lat));
    if (out_valid) begin
      for (int k = 0; k <= hold; k++) begin
        check("out_valid_held", W'(out_valid), W'(1));
        check($sformatf("BusW op=%b a=%h b=%h", op, a, b), BusW, er);
        check("Zero", W'(Zero), W'(er == '0));
        check("Negative", W'(Negative), W'(er[W-1]));
        check("Carry", W'(Carry), W'(ec));
        check("Overflow", W'(Overflow), W'(ev));
        check("in_ready_done", W'(in_ready), W'(0));
        if (k == hold) out_ready = 1'b1;
        @(negedge CLK);
      end
      out_ready = 1'b0;
      check("out_valid_drop", W'(out_valid), W'(0));
      check("in_ready_return", W'(in_ready), W'(1));
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return W'($urandom_range(0, 300));
      2:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    BusA = '0; BusB = '0; ALUCtrl = '0;
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_BusW", BusW, '0);
    check("rst_flags", W'({Zero, Negative, Carry, Overflow}), W'(0));
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    @(negedge CLK);

    // Directed corner cases.
    do_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    do_op(OP_SUB, 64'd5, 64'd5, 0, 1'b0);
    do_op(OP_SUB, 64'd3, 64'd5, 0, 1'b0);
    do_op(OP_MUL, 64'd12345, 64'd6789, 0, 1'b1);
    check("mul_const", BusW, 64'd83810205);
    do_op(OP_UDIV, 64'd100, 64'd7, 0, 1'b1);
    check("udiv_const", BusW, 64'd14);
    do_op(OP_UDIV, 64'd100, 64'd0, 0, 1'b0);
    do_op(OP_OR, 64'h00F0, 64'h0F00, 10, 1'b0);
    do_op(OP_AND, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 0, 1'b0);
    do_op(OP_PASSB, 64'd1, 64'h8000_0000_0000_0001, 0, 1'b0);
    do_op(OP_LSL, 64'h1, 64'd63, 0, 1'b0);
    do_op(OP_LSR, 64'h8000_0000_0000_0000, 64'h143, 0, 1'b0);
    do_op(4'b0101, 64'd9, 64'd9, 0, 1'b0);
    do_op(4'b1111, 64'd9, 64'd9, 0, 1'b0);
    do_op(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
    do_op(OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    do_op(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 0, 1'b0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; ALUCtrl = OP_MUL; BusA = 64'd77; BusB = 64'd99;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (29) @(negedge CLK);
    resetl = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_in_ready", W'(in_ready), W'(0));
    check("abort_BusW", BusW, '0);
    check("abort_flags", W'({Zero, Negative, Carry, Overflow}), W'(0));
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
    #1;
    check("abort_release_in_ready", W'(in_ready), W'(1));
    for (int k = 0; k < W + 4; k++) begin
      @(negedge CLK);
      check("abort_no_stale_valid", W'(out_valid), W'(0));
    end
    do_op(OP_ADD, 64'd2, 64'd3, 0, 1'b0);
    check("abort_add_result", BusW, 64'd5);

    // Randomized mix; iterative ops are rarer so the run stays short.
    for (int n = 0; n < 200; n++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = rand_operand();
      b  = rand_operand();
      if ((op == OP_LSL || op == OP_LSR) && $urandom_range(0, 1) == 0) b = W'($urandom_range(0, 200));
      do_op(op, a, b, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds iterative multiply and unsigned divide, logical shifts, and full NZCV flags alongside the existing AND/OR/ADD/SUB/PassB operations. It sits in the execute stage of the ARMv8 pipeline. Operands arrive on a valid/ready input port, and the result leaves on a valid/ready output port, so the pipeline can stall behind multi-cycle operations.

## Interface
- WIDTH, 64, operand/result width in bits; must be ≥ 8 and a power of two.
- CLK  in  1  rising-edge clock.
- resetl  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- BusA, BusB  in  WIDTH  operands.
- ALUCtrl  in  4  operation code.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer takes result.
- BusW  out  WIDTH  registered result.
- Zero, Negative, Carry, Overflow  out  1 each  registered flags.

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
  - LSL 0011: BusA << BusB[log2(WIDTH)-1:0].
  - LSR 0100: logical right shift, same amount field.
  - MUL 1000: low WIDTH bits of BusA*BusB.
  - UDIV 1001: unsigned quotient BusA/BusB.
  - Any other code gives BusW = 0.
- States are IDLE, CALC and DONE. Accept fires on in_valid && in_ready, and operands and opcode are latched at accept.
- From IDLE:
  - Single-cycle ops, and UDIV with BusB == 0, compute into BusW and go to DONE.
  - MUL and UDIV with nonzero divisor go to CALC with iteration counter = 0.
- CALC:
  - MUL: shift-add, one bit of B per cycle.
  - UDIV: restoring divide, one quotient bit per cycle.
  - After exactly WIDTH iterations the result is written to BusW and the FSM goes to DONE.
  - Inputs are ignored in CALC; in_ready = 0.
- DONE: out_valid = 1, and BusW and flags hold stable until out_ready. On out_ready the FSM returns to IDLE.
- UDIV by zero returns 0 (ARM semantics). MUL overflow is discarded silently.
- Flags:
  - Zero = (BusW == 0).
  - Negative = BusW[WIDTH-1].
  - ADD: Carry = carry-out, Overflow = signed overflow.
  - SUB: Carry = NOT borrow (A ≥ B unsigned), Overflow = signed overflow.
  - All other ops: Carry = Overflow = 0.
- Reset: all outputs are 0, except in_ready = 1 once reset is released. State = IDLE, counter = 0. Asserting resetl low mid-CALC or in DONE aborts the operation; the result is discarded and no out_valid is produced.

## Timing
- Single-cycle ops, divide-by-zero and undefined opcodes: out_valid rises in the cycle after accept (latency 1).
- MUL/UDIV: out_valid rises WIDTH+1 cycles after accept (accept → WIDTH CALC cycles → DONE).
- Back-to-back throughput:
  - Single-cycle ops: one result every 2 cycles with out_ready held high. DONE→IDLE takes one cycle, and in_ready is low in DONE.
  - MUL/UDIV: one result every WIDTH+2 cycles.
- out_valid, once high, stays high with BusW and flags unchanged until the cycle out_ready is sampled high.
- in_valid while in_ready is low has no effect; the producer must hold its request.
- Counter width is log2(WIDTH)+1 bits. Terminal count is WIDTH-1, with the result written on that cycle.

## Structure
- Shared package alu_pkg holds:
  - opcode constants (AND, OR, ADD, SUB, PassB, LSL, LSR, MUL, UDIV);
  - the FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
- Sub-module alu_iter_muldiv (parameter WIDTH) holds:
  - the iterative MUL/UDIV datapath: accumulator, remainder, shifting operand registers and iteration counter;
  - a start/mode input and a done pulse output.
- The top level owns the FSM, the handshake, the single-cycle combinational ops and flag generation.

## Test plan
- ADD overflow (WIDTH=64): A=0x7FFF_FFFF_FFFF_FFFF, B=1 → after 1 cycle BusW=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0.
- SUB equal operands: A=B=5 → BusW=0, Z=1, C=1, V=0. Then A=3, B=5 → BusW=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- MUL: A=12345, B=6789 → out_valid exactly 65 cycles after accept, BusW=83810205. in_ready stays 0 throughout CALC.
- UDIV: A=100, B=7 → BusW=14 after 65 cycles. Then A=100, B=0 → BusW=0, Z=1, out_valid after 1 cycle.
- Backpressure: complete an OR with out_ready=0 for 10 cycles → BusW/flags stable and in_ready=0. Raise out_ready → return to IDLE next cycle and accept the next op.
- Reset mid-MUL: assert resetl low in CALC cycle 30 → all outputs 0 immediately. After release, in_ready=1, no stale out_valid, and a following ADD 2+3 yields 5.
